// File: rtl/iob_cache_line_writeback.sv
// Purpose : write-back eviction channel; streams one dirty line from the data memory to the back-end.
// Latency : 3 cycles from wb_valid to the first be_valid, then 3 cycles per word (streaming build: 2 cycles, then 1 word per cycle).
// Backpr. : be_ready low holds be_valid/be_addr/be_wdata/be_wstrb stable; wb_valid is ignored while wb_busy.
// Optional: define IOB_CACHE_WB_PIPELINE_EN for streaming mode (no LOAD state, combinational data/address path).
// Ports   : clk_i/reset (async, active-high); wb_valid/wb_addr/wb_busy/wb_done to the cache controller;
//           line_raddr/line_rdata to the data memory (1-cycle read); be_valid/be_addr/be_wdata/be_wstrb/be_ready
//           to the back-end native write interface.
module iob_cache_line_writeback #(
    parameter int ADDR_W      = 32,
    parameter int BE_ADDR_W   = 32,
    parameter int BE_DATA_W   = 32,
    parameter int LINE2BE_W   = 2,
    localparam int BE_NBYTES_W = $clog2(BE_DATA_W / 8),
    localparam int LINE_W      = ADDR_W - BE_NBYTES_W - LINE2BE_W,
    localparam int RADDR_W     = (LINE2BE_W > 0) ? LINE2BE_W : 1
) (
    input  logic                   clk_i,
    input  logic                   reset,
    input  logic                   wb_valid,
    input  logic [LINE_W-1:0]      wb_addr,
    output logic                   wb_busy,
    output logic                   wb_done,
    output logic [RADDR_W-1:0]     line_raddr,
    input  logic [BE_DATA_W-1:0]   line_rdata,
    output logic                   be_valid,
    output logic [BE_ADDR_W-1:0]   be_addr,
    output logic [BE_DATA_W-1:0]   be_wdata,
    output logic [BE_DATA_W/8-1:0] be_wstrb,
    input  logic                   be_ready
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, DONE} state_t;

    state_t                       state, state_nxt;
    logic [LINE_W-1:0]            line_q;
    logic [RADDR_W-1:0]           cnt_q;
    logic                         cnt_last;
    logic [ADDR_W-BE_NBYTES_W-1:0] word_addr;
    logic [BE_ADDR_W-1:0]         addr_comb;
    logic                         start;
    logic                         hs;

    assign start = (state == IDLE) && wb_valid;
    assign hs    = (state == SEND) && be_ready;

    // Line address is captured once at acceptance and held for the whole line.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            line_q <= '0;
        end else if (start) begin
            line_q <= wb_addr;
        end
    end

    generate
        if (LINE2BE_W > 0) begin : g_cnt
            always_ff @(posedge clk_i or posedge reset) begin
                if (reset) begin
                    cnt_q <= '0;
                end else if (start) begin
                    cnt_q <= '0;
                end else if (hs && !cnt_last) begin
                    cnt_q <= cnt_q + RADDR_W'(1);
                end
            end
            assign cnt_last  = &cnt_q;
            assign word_addr = {line_q, cnt_q};
        end else begin : g_nocnt
            // Single-word line: no counter, the first handshake is the last.
            assign cnt_q     = '0;
            assign cnt_last  = 1'b1;
            assign word_addr = line_q;
        end
    endgenerate

    // Byte address: word address shifted over the byte-lane bits, zero-extended.
    always_comb begin
        addr_comb = '0;
        addr_comb[ADDR_W-BE_NBYTES_W-1:0] = word_addr;
        addr_comb = addr_comb << BE_NBYTES_W;
    end

    // State register
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (wb_valid) state_nxt = FETCH;
`ifdef IOB_CACHE_WB_PIPELINE_EN
            FETCH: state_nxt = SEND;
            SEND:  if (hs) state_nxt = cnt_last ? DONE : SEND;
`else
            FETCH: state_nxt = LOAD;
            SEND:  if (hs) state_nxt = cnt_last ? DONE : FETCH;
`endif
            LOAD:  state_nxt = SEND;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifndef IOB_CACHE_WB_PIPELINE_EN
    logic [BE_DATA_W-1:0] wdata_q;
    logic [BE_ADDR_W-1:0] addr_q;

    // Registered request: data arrives one cycle after FETCH, captured in LOAD.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            wdata_q <= '0;
            addr_q  <= '0;
        end else if (state == LOAD) begin
            wdata_q <= line_rdata;
            addr_q  <= addr_comb;
        end
    end
`endif

    // Output logic
    always_comb begin
        be_valid = (state == SEND);
        wb_busy  = (state != IDLE);
        wb_done  = (state == DONE);
        be_wstrb = be_valid ? '1 : '0;
`ifdef IOB_CACHE_WB_PIPELINE_EN
        // Read of the next word is issued in the handshake cycle; held during stalls
        // so line_rdata (and therefore be_wdata) stays stable.
        line_raddr = (LINE2BE_W > 0) ? cnt_q + RADDR_W'(hs) : '0;
        be_wdata   = be_valid ? line_rdata : '0;
        be_addr    = addr_comb;
`else
        line_raddr = cnt_q;
        be_wdata   = wdata_q;
        be_addr    = addr_q;
`endif
    end

endmodule

// File: tb/tb_iob_cache_line_writeback.sv
module tb_iob_cache_line_writeback;

`ifdef IOB_CACHE_WB_PIPELINE_EN
    localparam int LAT  = 2;
    localparam int WCYC = 1;
`else
    localparam int LAT  = 3;
    localparam int WCYC = 3;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk_i;
    logic        reset;
    // 4-word-line instance
    logic        wb_valid;
    logic [27:0] wb_addr;
    logic        wb_busy, wb_done;
    logic [1:0]  line_raddr;
    logic [31:0] line_rdata;
    logic        be_valid;
    logic [31:0] be_addr, be_wdata;
    logic [3:0]  be_wstrb;
    logic        be_ready;
    // single-word-line instance
    logic        wb_valid0;
    logic [29:0] wb_addr0;
    logic        wb_busy0, wb_done0;
    logic [0:0]  line_raddr0;
    logic [31:0] line_rdata0;
    logic        be_valid0;
    logic [31:0] be_addr0, be_wdata0;
    logic [3:0]  be_wstrb0;
    logic        be_ready0;

    logic [31:0] mem [4];

    exp_t sb_q[$];
    exp_t sb0_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt, done_cnt, vld_cnt, first_vld, last_vld, tick_no;
    int hs0_cnt, done0_cnt;

    iob_cache_line_writeback #(.ADDR_W(32), .BE_ADDR_W(32), .BE_DATA_W(32), .LINE2BE_W(2)) dut (
        .clk_i(clk_i), .reset(reset), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .wb_busy(wb_busy), .wb_done(wb_done), .line_raddr(line_raddr), .line_rdata(line_rdata),
        .be_valid(be_valid), .be_addr(be_addr), .be_wdata(be_wdata), .be_wstrb(be_wstrb),
        .be_ready(be_ready)
    );

    iob_cache_line_writeback #(.ADDR_W(32), .BE_ADDR_W(32), .BE_DATA_W(32), .LINE2BE_W(0)) dut0 (
        .clk_i(clk_i), .reset(reset), .wb_valid(wb_valid0), .wb_addr(wb_addr0),
        .wb_busy(wb_busy0), .wb_done(wb_done0), .line_raddr(line_raddr0), .line_rdata(line_rdata0),
        .be_valid(be_valid0), .be_addr(be_addr0), .be_wdata(be_wdata0), .be_wstrb(be_wstrb0),
        .be_ready(be_ready0)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Data memories with 1-cycle read latency
    always @(posedge clk_i) begin
        line_rdata  <= mem[line_raddr];
        line_rdata0 <= (line_raddr0 == 1'b0) ? 32'hA5A5A5A5 : 32'hDEADBEEF;
    end

    // One clock: sample at the falling edge (scoreboard pop/compare), return 1ns after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk_i);
        tick_no++;
        if (be_valid) begin
            if (vld_cnt == 0) first_vld = tick_no;
            last_vld = tick_no;
            vld_cnt++;
        end
        if (be_valid && be_ready) begin
            hs_cnt++;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra_write: addr=%h data=%h, no write expected", be_addr, be_wdata);
            end else begin
                e = sb_q.pop_front();
                if (be_addr !== e.addr || be_wdata !== e.data || be_wstrb !== 4'hF) begin
                    n_fail++;
                    $display("FAIL sb_write: got addr=%h data=%h wstrb=%h, want addr=%h data=%h wstrb=f",
                             be_addr, be_wdata, be_wstrb, e.addr, e.data);
                end
            end
        end
        if (wb_done) done_cnt++;
        if (be_valid0 && be_ready0) begin
            hs0_cnt++;
            n_checks++;
            if (sb0_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb0_extra_write: addr=%h data=%h, no write expected", be_addr0, be_wdata0);
            end else begin
                e = sb0_q.pop_front();
                if (be_addr0 !== e.addr || be_wdata0 !== e.data || be_wstrb0 !== 4'hF) begin
                    n_fail++;
                    $display("FAIL sb0_write: got addr=%h data=%h wstrb=%h, want addr=%h data=%h wstrb=f",
                             be_addr0, be_wdata0, be_wstrb0, e.addr, e.data);
                end
            end
        end
        if (wb_done0) done0_cnt++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_stats();
        hs_cnt = 0; done_cnt = 0; vld_cnt = 0; first_vld = 0; last_vld = 0; tick_no = 0;
        hs0_cnt = 0; done0_cnt = 0;
    endtask

    task automatic push_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) sb_q.push_back('{addr: base + 32'(4 * i), data: mem[i]});
    endtask

    task automatic start(input logic [27:0] a);
        wb_addr  = a;
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic wait_done(input bit sel0, input int budget, output bit timeout);
        int d0;
        d0 = sel0 ? done0_cnt : done_cnt;
        timeout = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((sel0 ? done0_cnt : done_cnt) > d0) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wb_valid = 1'b0; wb_addr = '0; be_ready = 1'b1;
        wb_valid0 = 1'b0; wb_addr0 = '0; be_ready0 = 1'b1;
        tick(); tick();
        n_checks++;
        if (be_valid !== 1'b0 || wb_busy !== 1'b0 || wb_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid=%b busy=%b done=%b, want 0 0 0", be_valid, wb_busy, wb_done);
        end
        n_checks++;
        if (be_wstrb !== 4'h0 || be_wdata !== 32'h0 || be_addr !== 32'h0 || line_raddr !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_data: wstrb=%h wdata=%h addr=%h raddr=%h, want all 0",
                     be_wstrb, be_wdata, be_addr, line_raddr);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit to;
        clear_stats();
        push_line(32'h400);
        n_checks++;
        if (wb_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle_busy: got %b want 0", wb_busy);
        end
        start(28'h0000040);
        n_checks++;
        if (wb_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy_rise: got %b want 1", wb_busy);
        end
        wait_done(1'b0, 60, to);
        n_checks++;
        if (to || hs_cnt != 4 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_line: timeout=%0d handshakes=%0d pending=%0d, want 0 4 0", to, hs_cnt, sb_q.size());
        end
        n_checks++;
        if (first_vld != LAT + 1) begin
            n_fail++;
            $display("FAIL basic_latency: first be_valid %0d cycles after wb_valid, want %0d", first_vld - 1, LAT);
        end
        n_checks++;
        if (vld_cnt != 4 || last_vld - first_vld != 3 * WCYC) begin
            n_fail++;
            $display("FAIL basic_cadence: valid cycles=%0d span=%0d, want 4 %0d", vld_cnt, last_vld - first_vld, 3 * WCYC);
        end
        tick(); tick();
        n_checks++;
        if (done_cnt != 1 || wb_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: done pulses=%0d busy=%b, want 1 0", done_cnt, wb_busy);
        end
    endtask

    task automatic test_backpressure();
        int stall;
        bit to;
        clear_stats();
        push_line(32'h400);
        stall = 0;
        to = 1'b1;
        start(28'h0000040);
        for (int i = 0; i < 80; i++) begin
            if (be_valid && be_addr == 32'h408 && stall < 5) begin
                n_checks++;
                if (be_valid !== 1'b1 || be_addr !== 32'h408 || be_wdata !== 32'h33333333 || be_wstrb !== 4'hF) begin
                    n_fail++;
                    $display("FAIL bp_stable: valid=%b addr=%h data=%h wstrb=%h, want 1 408 33333333 f",
                             be_valid, be_addr, be_wdata, be_wstrb);
                end
                be_ready = 1'b0;
                stall++;
            end else begin
                be_ready = 1'b1;
            end
            tick();
            if (done_cnt > 0) begin
                to = 1'b0;
                break;
            end
        end
        be_ready = 1'b1;
        n_checks++;
        if (to || stall != 5 || hs_cnt != 4 || done_cnt != 1 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_line: timeout=%0d stalls=%0d handshakes=%0d done=%0d pending=%0d, want 0 5 4 1 0",
                     to, stall, hs_cnt, done_cnt, sb_q.size());
        end
        tick();
    endtask

    task automatic test_busy_ignore();
        bit to;
        clear_stats();
        push_line(32'h400);
        start(28'h0000040);
        tick(); tick();
        wb_addr  = 28'h0000080;
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        wait_done(1'b0, 60, to);
        tick(); tick();
        n_checks++;
        if (to || hs_cnt != 4 || done_cnt != 1 || sb_q.size() != 0 || wb_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ignore: timeout=%0d handshakes=%0d done=%0d pending=%0d busy=%b, want 0 4 1 0 0",
                     to, hs_cnt, done_cnt, sb_q.size(), wb_busy);
        end
        push_line(32'h800);
        start(28'h0000080);
        wait_done(1'b0, 60, to);
        n_checks++;
        if (to || hs_cnt != 8 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL busy_next_line: timeout=%0d handshakes=%0d pending=%0d, want 0 8 0", to, hs_cnt, sb_q.size());
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_stats();
        push_line(32'h400);
        start(28'h0000040);
        to = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (hs_cnt == 2) begin
                to = 1'b0;
                break;
            end
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (to || be_valid !== 1'b0 || wb_busy !== 1'b0 || be_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_abort: timeout=%0d valid=%b busy=%b addr=%h, want 0 0 0 0", to, be_valid, wb_busy, be_addr);
        end
        sb_q.delete();
        tick(); tick(); tick();
        n_checks++;
        if (done_cnt != 0 || hs_cnt != 2) begin
            n_fail++;
            $display("FAIL rstmid_quiet: done=%0d handshakes=%0d, want 0 2", done_cnt, hs_cnt);
        end
        reset = 1'b0;
        tick();
        clear_stats();
        push_line(32'h400);
        start(28'h0000040);
        wait_done(1'b0, 60, to);
        n_checks++;
        if (to || hs_cnt != 4 || done_cnt != 1 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_restart: timeout=%0d handshakes=%0d done=%0d pending=%0d, want 0 4 1 0",
                     to, hs_cnt, done_cnt, sb_q.size());
        end
        tick();
    endtask

    task automatic test_single_word();
        bit to;
        clear_stats();
        sb0_q.push_back('{addr: 32'h400, data: 32'hA5A5A5A5});
        wb_addr0  = 30'h100;
        wb_valid0 = 1'b1;
        tick();
        wb_valid0 = 1'b0;
        wait_done(1'b1, 20, to);
        tick();
        n_checks++;
        if (to || hs0_cnt != 1 || done0_cnt != 1 || sb0_q.size() != 0 || wb_busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_word: timeout=%0d handshakes=%0d done=%0d pending=%0d busy=%b, want 0 1 1 0 0",
                     to, hs0_cnt, done0_cnt, sb0_q.size(), wb_busy0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[0] = 32'h11111111;
        mem[1] = 32'h22222222;
        mem[2] = 32'h33333333;
        mem[3] = 32'h44444444;
        clear_stats();
        test_reset();
        test_basic();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid();
        test_single_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iob_cache_line_writeback.md
Name: iob_cache_line_writeback

Overview:
- Write-back eviction channel for the cache back-end. It is the write counterpart of the line-fill read channel.
- On request, it reads one dirty cache line word by word from the data memory and writes each word to the back-end native memory interface.
- It holds busy until the last word is accepted, then pulses done.
- It sits between the cache controller/data memory and the back-end arbiter.

Parameters:
- ADDR_W, 32, front-end byte address width.
- BE_ADDR_W, 32, back-end byte address width.
- BE_DATA_W, 32, back-end data width in bits (power of 2, ≥8). Local BE_NBYTES_W = log2(BE_DATA_W/8).
- LINE2BE_W, 2, log2(back-end words per line). 0 means a single-word line.

Ports:
- clk_i, input, 1, clock.
- reset, input, 1, reset (asynchronous, active-high).
- wb_valid, input, 1, start write-back of the line at wb_addr. Sampled only in IDLE.
- wb_addr, input, ADDR_W-BE_NBYTES_W-LINE2BE_W, line address (byte address upper bits).
- wb_busy, output, 1, high in every state except IDLE.
- wb_done, output, 1, one-cycle pulse after the last word handshake.
- line_raddr, output, max(LINE2BE_W,1), word index into data memory. Memory read latency is 1 cycle.
- line_rdata, input, BE_DATA_W, data memory word for the line_raddr of the previous cycle.
- be_valid, output, 1, back-end write request.
- be_addr, output, BE_ADDR_W, {zero-extend, line address, word index, BE_NBYTES_W zeros}.
- be_wdata, output, BE_DATA_W, write data.
- be_wstrb, output, BE_DATA_W/8, all ones while be_valid, else 0.
- be_ready, input, 1, back-end accepts the word when be_valid & be_ready.

Behaviour:
- Reset values:
  - State = IDLE.
  - be_valid, wb_busy, wb_done = 0.
  - be_wstrb = 0, be_wdata = 0, be_addr = 0.
  - line_raddr = 0, word counter = 0.
- Reset asserted mid-line: abort immediately. Outputs return to reset values with no further handshake, and no done pulse is generated.
- IDLE:
  - wb_valid=1 latches wb_addr into the line register, clears the counter and moves to FETCH. wb_busy rises the next cycle.
  - wb_valid while busy is ignored.
- FETCH (1 cycle): line_raddr = counter. Next state is LOAD.
- LOAD (1 cycle): line_rdata is captured into the wdata register. be_addr is registered from {line, counter}. Next state is SEND.
- SEND:
  - be_valid=1, with be_addr, be_wdata and be_wstrb held stable until be_ready.
  - On handshake with counter == all-ones: go to DONE.
  - On handshake otherwise: counter+1 (no wrap beyond the last word), go to FETCH.
  - be_ready while be_valid=0 is ignored.
- DONE (1 cycle): wb_done=1, be_valid=0, next state is IDLE. wb_busy is still high in DONE.
- Throughput: 3 cycles per word, plus back-end wait cycles.
- Minimum latency: wb_valid to first be_valid is 3 cycles.
- LINE2BE_W=0:
  - No counter; line_raddr is tied to 0.
  - Exactly one word is sent, and the first handshake goes to DONE.
- The line address register is stable for the whole operation. A wb_addr change after acceptance has no effect.
- The address field is exactly ADDR_W-BE_NBYTES_W bits wide and zero-extended into BE_ADDR_W; BE_ADDR_W ≥ ADDR_W.

Optional Feature:
- Macro: IOB_CACHE_WB_PIPELINE_EN.
- With the macro defined: streaming mode.
  - States are IDLE → FETCH → SEND → DONE; there is no LOAD state.
  - be_wdata = line_rdata combinationally.
  - line_raddr = counter + (be_valid & be_ready) combinationally, so the next word's read is issued in the handshake cycle.
  - be_addr is combinational from the line register and counter.
  - With be_ready held high, one word is written per cycle: first be_valid 2 cycles after wb_valid, then back-to-back words.
  - When be_ready is low, line_raddr is held, so line_rdata and be_wdata stay stable.
- Without the macro: the registered 3-cycle/word behaviour above.

Test Plan:
- Basic line, LINE2BE_W=2, BE_DATA_W=32:
  - Stimulus: wb_addr=28'h0000040, memory words {11111111,22222222,33333333,44444444}, be_ready always 1.
  - Required: writes to 0x400, 0x404, 0x408, 0x40C with matching data and wstrb=4'hF; exactly one wb_done pulse; wb_busy low afterwards.
- Back-pressure:
  - Stimulus: be_ready low for 5 cycles on word 2.
  - Required: be_valid, be_addr=0x408 and be_wdata=33333333 stay stable all 5 cycles; no duplicate or skipped write; 4 handshakes total.
- Busy ignore:
  - Stimulus: pulse wb_valid with wb_addr=28'h0000080 during an active write-back.
  - Required: no write to 0x800; after done and a new wb_valid, 0x800–0x80C are written.
- Reset mid-line:
  - Stimulus: assert reset after the 2nd handshake.
  - Required: be_valid=0 and wb_busy=0 immediately; no wb_done; the next request restarts at word 0.
- LINE2BE_W=0:
  - Stimulus: wb_addr=30'h100, data=A5A5A5A5.
  - Required: a single write to 0x400, then wb_done.
- IOB_CACHE_WB_PIPELINE_EN defined, be_ready=1:
  - Required: 4 consecutive be_valid cycles starting 2 cycles after wb_valid, with correct data per address.
